msg_composer: RTL and testbench

- Line-editing stage directly downstream of the PS/2 ASCII decoder; consumes its `ascii`/`ascii_ready` one-cycle strobe.
- Builds a 16-character outgoing message, applying backspace and enter.
- Presents the completed message to the laser transmit framer over a valid/ready handshake.

---
 rtl/msg_composer.sv | 118 +++++++++++
 tb/tb_msg_composer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/msg_composer.sv
// msg_composer: line editor turning PS/2 ASCII strobes into a 16-char message offered over valid/ready; MSG_COMPOSER_FIFO_EN adds a type-ahead FIFO
module msg_composer #(
    parameter int MSG_CHARS  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clock_65mhz,
    input  logic                   reset_n,
    input  logic [7:0]             ascii,
    input  logic                   ascii_ready,
    output logic [8*MSG_CHARS-1:0] msg,
    output logic [4:0]             msg_len,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output logic                   overflow,
    output logic                   dropped
);
    typedef enum logic {EDIT, SEND} state_t;

    localparam logic [8*MSG_CHARS-1:0] BLANK = {MSG_CHARS{8'h20}};

    state_t                 state, state_nx;
    logic [8*MSG_CHARS-1:0] msg_nx;
    logic [4:0]             len_nx;
    logic                   ovf_nx, drp_nx;
    logic                   fifo_ne, pop, push, push_req, drop;
    logic [7:0]             ch;

    assign msg_valid = state == SEND;
    assign push_req  = ascii_ready && (state == SEND || fifo_ne);
    assign drop      = push_req && !push;

`ifdef MSG_COMPOSER_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;

    assign fifo_ne = count != '0;
    assign pop     = state == EDIT && fifo_ne;
    assign push    = push_req && (count != (AW+1)'(FIFO_DEPTH) || pop);
    assign ch      = fifo_ne ? fifo_mem[rd_ptr] : ascii;

    // FIFO pointers and occupancy; push and pop in one cycle leave count unchanged
    always_ff @(posedge clock_65mhz or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // FIFO storage needs no reset; occupancy guards every read
    always_ff @(posedge clock_65mhz) begin
        if (push) fifo_mem[wr_ptr] <= ascii;
    end
`else
    assign fifo_ne = 1'b0;
    assign pop     = 1'b0;
    assign push    = 1'b0;
    assign ch      = ascii;
`endif

    // Line editing in EDIT, handshake and clear-on-transfer in SEND
    always_comb begin
        state_nx = state;
        msg_nx   = msg;
        len_nx   = msg_len;
        ovf_nx   = overflow;
        drp_nx   = dropped | drop;
        if (state == SEND) begin
            if (msg_ready) begin
                state_nx = EDIT;
                msg_nx   = BLANK;
                len_nx   = '0;
                ovf_nx   = 1'b0;
                drp_nx   = drop;
            end
        end else if (fifo_ne || ascii_ready) begin
            if (ch >= 8'h20 && ch <= 8'h7E) begin
                if (int'(msg_len) < MSG_CHARS) begin
                    for (int i = 0; i < MSG_CHARS; i++)
                        if (int'(msg_len) == i) msg_nx[8*(MSG_CHARS-1-i) +: 8] = ch;
                    len_nx = msg_len + 5'd1;
                end else begin
                    ovf_nx = 1'b1;
                end
            end else if (ch == 8'h08 && msg_len != '0) begin
                for (int i = 0; i < MSG_CHARS; i++)
                    if (int'(msg_len) - 1 == i) msg_nx[8*(MSG_CHARS-1-i) +: 8] = 8'h20;
                len_nx = msg_len - 5'd1;
            end else if (ch == 8'h0D && msg_len != '0) begin
                state_nx = SEND;
            end
        end
    end

    // State and message registers
    always_ff @(posedge clock_65mhz or negedge reset_n) begin
        if (!reset_n) begin
            state    <= EDIT;
            msg      <= BLANK;
            msg_len  <= '0;
            overflow <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            state    <= state_nx;
            msg      <= msg_nx;
            msg_len  <= len_nx;
            overflow <= ovf_nx;
            dropped  <= drp_nx;
        end
    end
endmodule

// File: tb/tb_msg_composer.sv
// tb_msg_composer: table-driven and directed checks for msg_composer
module tb_msg_composer;
    logic         clock_65mhz = 1'b0;
    logic         reset_n = 1'b0;
    logic [7:0]   ascii = 8'h00;
    logic         ascii_ready = 1'b0;
    logic [127:0] msg;
    logic [4:0]   msg_len;
    logic         msg_valid;
    logic         msg_ready = 1'b0;
    logic         overflow;
    logic         dropped;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] BL = {16{8'h20}};

    msg_composer dut (
        .clock_65mhz(clock_65mhz),
        .reset_n(reset_n),
        .ascii(ascii),
        .ascii_ready(ascii_ready),
        .msg(msg),
        .msg_len(msg_len),
        .msg_valid(msg_valid),
        .msg_ready(msg_ready),
        .overflow(overflow),
        .dropped(dropped)
    );

    always #5 clock_65mhz = ~clock_65mhz;

    typedef struct {
        logic [7:0]   a;
        logic         r;
        logic [127:0] m;
        logic [4:0]   l;
        logic         ovf;
    } vec_t;

    vec_t v [16];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] a, input logic r);
        ascii = a;
        ascii_ready = r;
        @(posedge clock_65mhz);
        #1;
        ascii_ready = 1'b0;
    endtask

    initial begin
        v[0]  = '{8'h41, 1'b1, {8'h41, {15{8'h20}}}, 5'd1, 1'b0};
        v[1]  = '{8'h42, 1'b1, {8'h41, 8'h42, {14{8'h20}}}, 5'd2, 1'b0};
        v[2]  = '{8'h43, 1'b1, {8'h41, 8'h42, 8'h43, {13{8'h20}}}, 5'd3, 1'b0};
        v[3]  = '{8'h44, 1'b0, {8'h41, 8'h42, 8'h43, {13{8'h20}}}, 5'd3, 1'b0};
        v[4]  = '{8'h07, 1'b1, {8'h41, 8'h42, 8'h43, {13{8'h20}}}, 5'd3, 1'b0};
        v[5]  = '{8'h08, 1'b1, {8'h41, 8'h42, {14{8'h20}}}, 5'd2, 1'b0};
        v[6]  = '{8'h08, 1'b1, {8'h41, {15{8'h20}}}, 5'd1, 1'b0};
        v[7]  = '{8'h08, 1'b1, BL, 5'd0, 1'b0};
        v[8]  = '{8'h08, 1'b1, BL, 5'd0, 1'b0};
        v[9]  = '{8'h0D, 1'b1, BL, 5'd0, 1'b0};
        v[10] = '{8'h7F, 1'b1, BL, 5'd0, 1'b0};
        v[11] = '{8'h7E, 1'b1, {8'h7E, {15{8'h20}}}, 5'd1, 1'b0};
        v[12] = '{8'h1F, 1'b1, {8'h7E, {15{8'h20}}}, 5'd1, 1'b0};
        v[13] = '{8'h20, 1'b1, {8'h7E, {15{8'h20}}}, 5'd2, 1'b0};
        v[14] = '{8'h08, 1'b1, {8'h7E, {15{8'h20}}}, 5'd1, 1'b0};
        v[15] = '{8'h08, 1'b1, BL, 5'd0, 1'b0};

        repeat (3) @(posedge clock_65mhz);
        #1;
        chk("reset_msg", msg, BL);
        chk("reset_len", 128'(msg_len), 128'd0);
        chk("reset_valid", 128'(msg_valid), 128'd0);
        chk("reset_ovf", 128'(overflow), 128'd0);
        chk("reset_drp", 128'(dropped), 128'd0);
        @(negedge clock_65mhz);
        reset_n = 1'b1;
        @(posedge clock_65mhz);
        #1;

        for (int i = 0; i < 16; i++) begin
            step(v[i].a, v[i].r);
            chk($sformatf("tbl%0d_msg", i), msg, v[i].m);
            chk($sformatf("tbl%0d_len", i), 128'(msg_len), 128'(v[i].l));
            chk($sformatf("tbl%0d_ovf", i), 128'(overflow), 128'(v[i].ovf));
            chk($sformatf("tbl%0d_valid", i), 128'(msg_valid), 128'd0);
            chk($sformatf("tbl%0d_drp", i), 128'(dropped), 128'd0);
        end

        step(8'h48, 1'b1);
        step(8'h49, 1'b1);
        step(8'h0D, 1'b1);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hold%0d_valid", c), 128'(msg_valid), 128'd1);
            chk($sformatf("hold%0d_msg", c), msg, {8'h48, 8'h49, {14{8'h20}}});
            chk($sformatf("hold%0d_len", c), 128'(msg_len), 128'd2);
            if (c == 1) step(8'h59, 1'b1);
            else if (c == 2) step(8'h5A, 1'b1);
            else step(8'h00, 1'b0);
        end
`ifdef MSG_COMPOSER_FIFO_EN
        chk("send_drp", 128'(dropped), 128'd0);
`else
        chk("send_drp", 128'(dropped), 128'd1);
`endif
        msg_ready = 1'b1;
        step(8'h00, 1'b0);
        msg_ready = 1'b0;
        chk("xfer_valid", 128'(msg_valid), 128'd0);
        chk("xfer_len", 128'(msg_len), 128'd0);
        chk("xfer_msg", msg, BL);
        chk("xfer_drp", 128'(dropped), 128'd0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
`ifdef MSG_COMPOSER_FIFO_EN
        chk("drain_len", 128'(msg_len), 128'd2);
        chk("drain_msg", msg, {8'h59, 8'h5A, {14{8'h20}}});
`else
        chk("drain_len", 128'(msg_len), 128'd0);
        chk("drain_msg", msg, BL);
`endif
        step(8'h08, 1'b1);
        step(8'h08, 1'b1);
        chk("clr_len", 128'(msg_len), 128'd0);

        for (int i = 0; i < 16; i++) step(8'h58, 1'b1);
        chk("full_len", 128'(msg_len), 128'd16);
        chk("full_msg", msg, {16{8'h58}});
        chk("full_ovf", 128'(overflow), 128'd0);
        step(8'h58, 1'b1);
        chk("ovf_len", 128'(msg_len), 128'd16);
        chk("ovf_msg", msg, {16{8'h58}});
        chk("ovf_flag", 128'(overflow), 128'd1);
        msg_ready = 1'b1;
        step(8'h0D, 1'b1);
        chk("early_rdy_valid", 128'(msg_valid), 128'd1);
        chk("early_rdy_len", 128'(msg_len), 128'd16);
        step(8'h00, 1'b0);
        msg_ready = 1'b0;
        chk("min_send_valid", 128'(msg_valid), 128'd0);
        chk("min_send_len", 128'(msg_len), 128'd0);
        chk("min_send_ovf", 128'(overflow), 128'd0);

        for (int i = 0; i < 5; i++) step(8'(8'h61 + i), 1'b1);
        step(8'h0D, 1'b1);
        chk("rst_pre_valid", 128'(msg_valid), 128'd1);
        chk("rst_pre_len", 128'(msg_len), 128'd5);
        step(8'h66, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_valid", 128'(msg_valid), 128'd0);
        chk("rst_len", 128'(msg_len), 128'd0);
        chk("rst_msg", msg, BL);
        chk("rst_ovf", 128'(overflow), 128'd0);
        chk("rst_drp", 128'(dropped), 128'd0);
        @(negedge clock_65mhz);
        reset_n = 1'b1;
        step(8'h00, 1'b0);
        chk("post_rst_valid", 128'(msg_valid), 128'd0);
        chk("post_rst_len", 128'(msg_len), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
